// File: rtl/cmd_pkg.sv
// Shared command/error encodings and decoder state enum for the UART register file.
// Combinational helpers only; no latency or backpressure.
package cmd_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_C = 8'h43;

    localparam logic [7:0] ERR_UNKNOWN_CMD = 8'h01;
    localparam logic [7:0] ERR_BAD_ADDR    = 8'h02;
    localparam logic [7:0] ERR_READ_ONLY   = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        RD_ISSUE,
        RD_WAIT,
        EXEC,
        RESP
    } state_t;

    function automatic logic is_known_cmd(input logic [7:0] c);
        return (c == CMD_W) || (c == CMD_R) || (c == CMD_S) || (c == CMD_C);
    endfunction

endpackage

// File: rtl/rd_latency_ctr.sv
// Counts regfile read latency and flags the cycle in which reg_rd_data is valid.
// capture is combinational: in the issue cycle for RD_LATENCY=0, else RD_LATENCY cycles later.
// No backpressure; start restarts the count unconditionally.
module rd_latency_ctr #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic wait_en,
    output logic capture
);

    logic [2:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 3'd0;
        end else if (start) begin
            cnt <= 3'(RD_LATENCY);
        end else if (wait_en && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end

    assign capture = start ? (RD_LATENCY == 0) : (wait_en && cnt == 3'd1);

endmodule

// File: rtl/cmd_decoder_param.sv
// Decodes latched W/R/S/C commands into regfile accesses with one response pulse each.
// W/errors respond at N+2, R/S/C at N+3+RD_LATENCY; back to IDLE the cycle after.
// No backpressure: cmd_ready while busy is dropped and counted in overrun_cnt.
module cmd_decoder_param import cmd_pkg::*; #(
    parameter int                  NUM_REGS   = 16,
    parameter int                  RD_LATENCY = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter int                  AW         = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_ready,
    input  logic [7:0]    cmd,
    input  logic [7:0]    addr,
    input  logic [7:0]    data,
    input  logic [7:0]    reg_rd_data,
    output logic          reg_rd_en,
    output logic          reg_wr_en,
    output logic [AW-1:0] reg_addr,
    output logic [7:0]    reg_wr_data,
    output logic          resp_ok,
    output logic          resp_data,
    output logic          resp_err,
    output logic [7:0]    resp_addr,
    output logic [7:0]    resp_data_byte,
    output logic [7:0]    resp_err_code,
    output logic          busy,
    output logic [7:0]    overrun_cnt
);

    state_t     state;
    logic [7:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;
    logic [7:0] err_code;
    logic [7:0] rmw_val;
    logic       capture;

    rd_latency_ctr #(.RD_LATENCY(RD_LATENCY)) u_rd_latency_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (state == RD_ISSUE),
        .wait_en (state == RD_WAIT),
        .capture (capture)
    );

    assign busy = (state != IDLE);

    // Full 8-bit address is range-checked so aliases above NUM_REGS are rejected.
    always_comb begin
        err_code = 8'h00;
        if (!is_known_cmd(cmd_q)) begin
            err_code = ERR_UNKNOWN_CMD;
        end else if ({1'b0, addr_q} >= 9'(NUM_REGS)) begin
            err_code = ERR_BAD_ADDR;
        end else if (cmd_q != CMD_R && RO_MASK[addr_q[AW-1:0]]) begin
            err_code = ERR_READ_ONLY;
        end
    end

    always_comb begin
        rmw_val = (cmd_q == CMD_S) ? (reg_rd_data | data_q) : (reg_rd_data & ~data_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cmd_q          <= 8'h00;
            addr_q         <= 8'h00;
            data_q         <= 8'h00;
            reg_rd_en      <= 1'b0;
            reg_wr_en      <= 1'b0;
            reg_addr       <= '0;
            reg_wr_data    <= 8'h00;
            resp_ok        <= 1'b0;
            resp_data      <= 1'b0;
            resp_err       <= 1'b0;
            resp_addr      <= 8'h00;
            resp_data_byte <= 8'h00;
            resp_err_code  <= 8'h00;
            overrun_cnt    <= 8'h00;
        end else begin
            reg_rd_en <= 1'b0;
            reg_wr_en <= 1'b0;
            resp_ok   <= 1'b0;
            resp_data <= 1'b0;
            resp_err  <= 1'b0;

            if (cmd_ready && state != IDLE && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (cmd_ready) begin
                        cmd_q    <= cmd;
                        addr_q   <= addr;
                        data_q   <= data;
                        reg_addr <= addr[AW-1:0];
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    if (err_code != 8'h00) begin
                        resp_err       <= 1'b1;
                        resp_err_code  <= err_code;
                        resp_addr      <= addr_q;
                        resp_data_byte <= 8'h00;
                        state          <= RESP;
                    end else if (cmd_q == CMD_W) begin
                        reg_wr_en      <= 1'b1;
                        reg_wr_data    <= data_q;
                        resp_ok        <= 1'b1;
                        resp_addr      <= addr_q;
                        resp_data_byte <= data_q;
                        state          <= EXEC;
                    end else begin
                        reg_rd_en <= 1'b1;
                        state     <= RD_ISSUE;
                    end
                end
                RD_ISSUE, RD_WAIT: begin
                    if (!capture) begin
                        state <= RD_WAIT;
                    end else if (cmd_q == CMD_R) begin
                        resp_data      <= 1'b1;
                        resp_addr      <= addr_q;
                        resp_data_byte <= reg_rd_data;
                        state          <= RESP;
                    end else begin
                        reg_wr_en      <= 1'b1;
                        reg_wr_data    <= rmw_val;
                        resp_ok        <= 1'b1;
                        resp_addr      <= addr_q;
                        resp_data_byte <= rmw_val;
                        state          <= EXEC;
                    end
                end
                EXEC, RESP: state <= IDLE;
                default:    state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_decoder_param.sv
// Directed bench: instances 0..2 are 16 regs at RD_LATENCY 0/1/3, instance 3 is 12 regs with reg 2 read-only.
module tb_cmd_decoder_param;
    import cmd_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] cmd_ready;
    logic [7:0] cmd, addr, data, reg_rd_data;
    logic [3:0] reg_rd_en, reg_wr_en, resp_ok, resp_data, resp_err, busy;
    logic [3:0] reg_addr [4];
    logic [7:0] reg_wr_data [4];
    logic [7:0] resp_addr [4];
    logic [7:0] resp_data_byte [4];
    logic [7:0] resp_err_code [4];
    logic [7:0] overrun_cnt [4];

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_dut
            cmd_decoder_param #(.NUM_REGS(16), .RD_LATENCY(g == 2 ? 3 : g)) u_dut (
                .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready[g]),
                .cmd(cmd), .addr(addr), .data(data), .reg_rd_data(reg_rd_data),
                .reg_rd_en(reg_rd_en[g]), .reg_wr_en(reg_wr_en[g]), .reg_addr(reg_addr[g]),
                .reg_wr_data(reg_wr_data[g]), .resp_ok(resp_ok[g]), .resp_data(resp_data[g]),
                .resp_err(resp_err[g]), .resp_addr(resp_addr[g]), .resp_data_byte(resp_data_byte[g]),
                .resp_err_code(resp_err_code[g]), .busy(busy[g]), .overrun_cnt(overrun_cnt[g])
            );
        end
    endgenerate

    cmd_decoder_param #(.NUM_REGS(12), .RD_LATENCY(1), .RO_MASK(12'h004)) u_dut12 (
        .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready[3]),
        .cmd(cmd), .addr(addr), .data(data), .reg_rd_data(reg_rd_data),
        .reg_rd_en(reg_rd_en[3]), .reg_wr_en(reg_wr_en[3]), .reg_addr(reg_addr[3]),
        .reg_wr_data(reg_wr_data[3]), .resp_ok(resp_ok[3]), .resp_data(resp_data[3]),
        .resp_err(resp_err[3]), .resp_addr(resp_addr[3]), .resp_data_byte(resp_data_byte[3]),
        .resp_err_code(resp_err_code[3]), .busy(busy[3]), .overrun_cnt(overrun_cnt[3])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs(input int i);
        return 64'({reg_rd_en[i], reg_wr_en[i], reg_addr[i], reg_wr_data[i], resp_ok[i],
                    resp_data[i], resp_err[i], resp_addr[i], resp_data_byte[i],
                    resp_err_code[i], busy[i], overrun_cnt[i]});
    endfunction

    task automatic send(input int i, input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cmd = c; addr = a; data = d;
        cmd_ready[i] = 1'b1;
        @(negedge clk);
        cmd_ready[i] = 1'b0;
    endtask

    // Observation results; cycle k=1 is the cycle after the command strobe.
    int n_ok, n_dat, n_err, c_resp, n_wr, c_wr, n_rd, c_rd;
    logic [7:0] o_addr, o_byte, o_code, o_wrd;
    logic [3:0] o_rega;

    task automatic observe(input int i, input int n);
        n_ok = 0; n_dat = 0; n_err = 0; c_resp = 0;
        n_wr = 0; c_wr = 0; n_rd = 0; c_rd = 0;
        o_addr = 8'h00; o_byte = 8'h00; o_code = 8'h00; o_wrd = 8'h00; o_rega = 4'h0;
        for (int k = 1; k <= n; k++) begin
            if (resp_ok[i])   n_ok++;
            if (resp_data[i]) n_dat++;
            if (resp_err[i])  n_err++;
            if (resp_ok[i] || resp_data[i] || resp_err[i]) begin
                if (c_resp == 0) c_resp = k;
                o_addr = resp_addr[i];
                o_byte = resp_data_byte[i];
                o_code = resp_err_code[i];
                o_rega = reg_addr[i];
            end
            if (reg_wr_en[i]) begin
                n_wr++;
                if (c_wr == 0) c_wr = k;
                o_wrd = reg_wr_data[i];
            end
            if (reg_rd_en[i]) begin
                n_rd++;
                if (c_rd == 0) c_rd = k;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int         idx;
        logic [7:0] c, a, d, rd;
        int         kind;    // 0 ok, 1 data, 2 err
        int         cyc;
        logic [7:0] byte_v;
        logic [7:0] code;
        int         wr_cyc;  // 0 means no write expected
        logic [7:0] wr_d;
        int         rd_cyc;  // 0 means no read expected
    } vec_t;

    vec_t vecs [16];

    initial begin
        vecs[0]  = '{1, CMD_W, 8'h03, 8'hB3, 8'h00, 0, 2, 8'h00, 8'h00, 2, 8'hB3, 0};
        vecs[1]  = '{0, CMD_R, 8'h03, 8'h00, 8'h5A, 1, 3, 8'h5A, 8'h00, 0, 8'h00, 2};
        vecs[2]  = '{1, CMD_R, 8'h03, 8'h00, 8'h5A, 1, 4, 8'h5A, 8'h00, 0, 8'h00, 2};
        vecs[3]  = '{2, CMD_R, 8'h03, 8'h00, 8'h5A, 1, 6, 8'h5A, 8'h00, 0, 8'h00, 2};
        vecs[4]  = '{1, CMD_S, 8'h05, 8'hF0, 8'h0F, 0, 4, 8'hFF, 8'h00, 4, 8'hFF, 2};
        vecs[5]  = '{1, CMD_C, 8'h05, 8'h0F, 8'hFF, 0, 4, 8'hF0, 8'h00, 4, 8'hF0, 2};
        vecs[6]  = '{3, CMD_W, 8'h0C, 8'h11, 8'h00, 2, 2, 8'h00, 8'h02, 0, 8'h00, 0};
        vecs[7]  = '{3, 8'h99, 8'h02, 8'h11, 8'h00, 2, 2, 8'h00, 8'h01, 0, 8'h00, 0};
        vecs[8]  = '{3, CMD_W, 8'h02, 8'h11, 8'h00, 2, 2, 8'h00, 8'h03, 0, 8'h00, 0};
        vecs[9]  = '{3, CMD_R, 8'h02, 8'h00, 8'h5A, 1, 4, 8'h5A, 8'h00, 0, 8'h00, 2};
        vecs[10] = '{3, CMD_S, 8'h02, 8'h01, 8'h5A, 2, 2, 8'h00, 8'h03, 0, 8'h00, 0};
        vecs[11] = '{0, CMD_S, 8'h07, 8'h80, 8'h01, 0, 3, 8'h81, 8'h00, 3, 8'h81, 2};
        vecs[12] = '{2, CMD_C, 8'h09, 8'hFF, 8'h3C, 0, 6, 8'h00, 8'h00, 6, 8'h00, 2};
        vecs[13] = '{3, CMD_W, 8'h0B, 8'h77, 8'h00, 0, 2, 8'h00, 8'h00, 2, 8'h77, 0};
        vecs[14] = '{1, 8'h99, 8'hFF, 8'h00, 8'h00, 2, 2, 8'h00, 8'h01, 0, 8'h00, 0};
        vecs[15] = '{3, CMD_R, 8'h0C, 8'h00, 8'h5A, 2, 2, 8'h00, 8'h02, 0, 8'h00, 0};

        cmd_ready = 4'h0; cmd = 8'h00; addr = 8'h00; data = 8'h00; reg_rd_data = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) check($sformatf("reset_outs[%0d]", i), all_outs(i), 64'h0);
        rst_n = 1'b1;

        for (int v = 0; v < 16; v++) begin
            reg_rd_data = vecs[v].rd;
            send(vecs[v].idx, vecs[v].c, vecs[v].a, vecs[v].d);
            check($sformatf("v%0d busy", v), 64'(busy[vecs[v].idx]), 64'h1);
            observe(vecs[v].idx, 10);
            check($sformatf("v%0d kinds ok/data/err", v), 64'(n_ok * 100 + n_dat * 10 + n_err),
                  64'(vecs[v].kind == 0 ? 100 : (vecs[v].kind == 1 ? 10 : 1)));
            check($sformatf("v%0d resp_cycle", v), 64'(c_resp), 64'(vecs[v].cyc));
            check($sformatf("v%0d resp_addr", v), 64'(o_addr), 64'(vecs[v].a));
            check($sformatf("v%0d reg_addr", v), 64'(o_rega), 64'(vecs[v].a[3:0]));
            if (!(vecs[v].kind == 0 && vecs[v].c == CMD_W))
                check($sformatf("v%0d resp_data_byte", v), 64'(o_byte), 64'(vecs[v].byte_v));
            if (vecs[v].kind == 2)
                check($sformatf("v%0d err_code", v), 64'(o_code), 64'(vecs[v].code));
            check($sformatf("v%0d wr_count", v), 64'(n_wr), 64'(vecs[v].wr_cyc != 0 ? 1 : 0));
            check($sformatf("v%0d wr_cycle", v), 64'(c_wr), 64'(vecs[v].wr_cyc));
            if (vecs[v].wr_cyc != 0)
                check($sformatf("v%0d wr_data", v), 64'(o_wrd), 64'(vecs[v].wr_d));
            check($sformatf("v%0d rd_count", v), 64'(n_rd), 64'(vecs[v].rd_cyc != 0 ? 1 : 0));
            check($sformatf("v%0d rd_cycle", v), 64'(c_rd), 64'(vecs[v].rd_cyc));
        end

        // W, strobe in its response cycle (dropped), then W at minimum spacing 3.
        @(negedge clk);
        cmd = CMD_W; addr = 8'h04; data = 8'h22; cmd_ready[1] = 1'b1;
        @(negedge clk); cmd_ready[1] = 1'b0;
        @(negedge clk); addr = 8'h06; data = 8'h33; cmd_ready[1] = 1'b1;
        @(negedge clk); addr = 8'h07; data = 8'h44;
        @(negedge clk); cmd_ready[1] = 1'b0;
        observe(1, 6);
        check("b2b kinds", 64'(n_ok * 100 + n_dat * 10 + n_err), 64'd100);
        check("b2b resp_cycle", 64'(c_resp), 64'd2);
        check("b2b wr_data", 64'(o_wrd), 64'h44);
        check("b2b resp_addr", 64'(o_addr), 64'h07);
        check("b2b overrun", 64'(overrun_cnt[1]), 64'd1);

        // R at RD_LATENCY=3 with strobes repeated at N+1 and N+2.
        reg_rd_data = 8'h5A;
        @(negedge clk);
        cmd = CMD_R; addr = 8'h03; data = 8'h00; cmd_ready[2] = 1'b1;
        repeat (3) @(negedge clk);
        cmd_ready[2] = 1'b0;
        observe(2, 10);
        check("ovr kinds", 64'(n_ok * 100 + n_dat * 10 + n_err), 64'd10);
        check("ovr resp_cycle", 64'(c_resp), 64'd4);
        check("ovr resp_data_byte", 64'(o_byte), 64'h5A);
        check("ovr overrun_2", 64'(overrun_cnt[2]), 64'd2);

        // Continuous strobe from IDLE: accept, drop 6, accept, drop 6.
        cmd_ready[2] = 1'b1;
        repeat (14) @(negedge clk);
        cmd_ready[2] = 1'b0;
        check("ovr overrun_14", 64'(overrun_cnt[2]), 64'd14);
        cmd_ready[2] = 1'b1;
        repeat (300) @(negedge clk);
        cmd_ready[2] = 1'b0;
        check("ovr saturate", 64'(overrun_cnt[2]), 64'hFF);
        repeat (10) @(negedge clk);

        // Reset asserted during RD_WAIT.
        send(2, CMD_R, 8'h03, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid outs", all_outs(2), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        observe(2, 8);
        check("rst_mid no_resp", 64'(n_ok + n_dat + n_err), 64'd0);
        check("rst_mid no_wr", 64'(n_wr), 64'd0);
        send(2, CMD_W, 8'h01, 8'hAA);
        observe(2, 6);
        check("post_rst kinds", 64'(n_ok * 100 + n_dat * 10 + n_err), 64'd100);
        check("post_rst resp_cycle", 64'(c_resp), 64'd2);
        check("post_rst wr_data", 64'(o_wrd), 64'hAA);
        check("post_rst resp_addr", 64'(o_addr), 64'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
